// File: rtl/m0_pkg.sv
// m0_pkg: shared definitions for the Cortex-M0 register-list transfer path.
//   - state_t          : sequencer FSM states
//   - WORD_BYTES       : bytes per transfer
//   - REG_LR / REG_PC  : architectural indices for list bits 8 and 9
//   - list_bit_to_reg(): maps a register-list bit position to a register index
package m0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // List bit positions that do not map 1:1 onto register numbers
  localparam int LIST_BIT_LR = 8;
  localparam int LIST_BIT_PC = 9;

  function automatic logic [3:0] list_bit_to_reg(input int b);
    if (b == LIST_BIT_LR) begin
      return REG_LR;
    end else if (b == LIST_BIT_PC) begin
      return REG_PC;
    end else begin
      return 4'(b);
    end
  endfunction

endpackage

// File: rtl/reg_list_seq_lowest_set_idx.sv
// lowest_set_idx: combinational priority encoder for a register list.
// Ports:
//   list     in  LIST_W : remaining register list
//   idx      out 4      : register index of the lowest set bit (0 if list empty)
//   clr_mask out LIST_W : one-hot mask of that bit (all zero if list empty)
module lowest_set_idx
  import m0_pkg::*;
#(
  parameter int LIST_W = 10
) (
  input  logic [LIST_W-1:0] list,
  output logic [3:0]        idx,
  output logic [LIST_W-1:0] clr_mask
);

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    idx      = 4'd0;
    clr_mask = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) begin
        idx         = list_bit_to_reg(i);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_list_seq.sv
// reg_list_seq: LDM/STM/PUSH/POP register-list transfer sequencer.
// Walks the captured list lowest register first, one word transfer per
// req_valid & req_ready handshake, then pulses done with the base write-back.
// Optional feature macro: REG_LIST_ALIGN_CHECK_EN (fault on unaligned base).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request a sequence (only sampled in IDLE)
//   list_in, base_addr, decr : captured on an accepted start
//   busy                : sequence in progress (through the done cycle)
//   req_valid/req_ready : transfer handshake
//   req_reg, req_addr, req_last : current transfer register, address, final flag
//   done                : one-cycle completion pulse
//   wb_addr             : base write-back value, held until next accepted start
//   fault               : one-cycle alignment fault pulse (0 without the macro)
module reg_list_seq
  import m0_pkg::*;
#(
  parameter int WIDTH_ADDR = 32,
  parameter int LIST_W     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LIST_W-1:0]     list_in,
  input  logic [WIDTH_ADDR-1:0] base_addr,
  input  logic                  decr,
  output logic                  busy,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [3:0]            req_reg,
  output logic [WIDTH_ADDR-1:0] req_addr,
  output logic                  req_last,
  output logic                  done,
  output logic [WIDTH_ADDR-1:0] wb_addr,
  output logic                  fault
);

  state_t                state, state_next;
  logic [LIST_W-1:0]     list_rem;
  logic [WIDTH_ADDR-1:0] addr;
  logic [WIDTH_ADDR-1:0] wb_pend;
  logic [3:0]            cur_idx;
  logic [LIST_W-1:0]     clr_mask;
  logic [3:0]            n_regs;
  logic [WIDTH_ADDR-1:0] offset;
  logic [WIDTH_ADDR-1:0] first_addr;
  logic [WIDTH_ADDR-1:0] wb_calc;
  logic                  start_ok;
  logic                  misaligned;
  logic                  hs;
  logic                  last_bit;

  lowest_set_idx #(.LIST_W(LIST_W)) u_enc (
    .list     (list_rem),
    .idx      (cur_idx),
    .clr_mask (clr_mask)
  );

`ifdef REG_LIST_ALIGN_CHECK_EN
  assign misaligned = (base_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign start_ok = (state == ST_IDLE) && start;
  assign hs       = (state == ST_XFER) && req_ready;
  // Only one bit left in the remaining list
  assign last_bit = ((list_rem & ~clr_mask) == '0);

  // Popcount of the incoming list; only meaningful on an accepted start.
  always_comb begin
    n_regs = 4'd0;
    for (int i = 0; i < LIST_W; i++) begin
      n_regs = n_regs + {3'b000, list_in[i]};
    end
  end

  assign offset     = WIDTH_ADDR'(n_regs) * WIDTH_ADDR'(WORD_BYTES);
  assign first_addr = decr ? (base_addr - offset) : base_addr;
  // Decrement-before writes back the lowest address; increment-after the end.
  assign wb_calc    = misaligned ? base_addr :
                      (decr ? (base_addr - offset) : (base_addr + offset));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (misaligned || (list_in == '0)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (req_ready && last_bit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_rem <= '0;
      addr     <= '0;
      wb_pend  <= '0;
      wb_addr  <= '0;
      fault    <= 1'b0;
    end else begin
      fault <= start_ok && misaligned;
      if (start_ok) begin
        list_rem <= misaligned ? '0 : list_in;
        addr     <= first_addr;
        wb_pend  <= wb_calc;
        // Sequences that skip XFER publish the write-back with done at T+1
        if (misaligned || (list_in == '0)) begin
          wb_addr <= wb_calc;
        end
      end else if (hs) begin
        list_rem <= list_rem & ~clr_mask;
        addr     <= addr + WIDTH_ADDR'(WORD_BYTES);
        if (last_bit) begin
          wb_addr <= wb_pend;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign req_valid = (state == ST_XFER);
  assign done      = (state == ST_DONE);
  assign req_reg   = cur_idx;
  assign req_addr  = addr;
  assign req_last  = req_valid && last_bit;

endmodule

// File: tb/tb_reg_list_seq.sv
// tb_reg_list_seq: table-driven bench with a transfer scoreboard for reg_list_seq.
// Honors REG_LIST_ALIGN_CHECK_EN the same way as the design.
module tb_reg_list_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  list_in;
  logic [31:0] base_addr;
  logic        decr;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_reg;
  logic [31:0] req_addr;
  logic        req_last;
  logic        done;
  logic [31:0] wb_addr;
  logic        fault;

  reg_list_seq #(.WIDTH_ADDR(32), .LIST_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .list_in   (list_in),
    .base_addr (base_addr),
    .decr      (decr),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_addr  (req_addr),
    .req_last  (req_last),
    .done      (done),
    .wb_addr   (wb_addr),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  list;
    logic [31:0] base;
    logic        decr;
    int          n;
    logic [31:0] wb;
    int          stall;
    bit          mid_start;
  } vec_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic        last;
  } xfer_t;

  xfer_t exp_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [3:0] bit2reg(input int b);
    if (b == 8) return 4'd14;
    if (b == 9) return 4'd15;
    return 4'(b);
  endfunction

  // Scoreboard model: expected transfers for one list, in issue order.
  task automatic push_model(input logic [9:0] list, input logic [31:0] base, input logic d);
    int n = 0;
    int k = 0;
    logic [31:0] a;
    xfer_t x;
    for (int b = 0; b < 10; b++) if (list[b]) n++;
    a = d ? base - 32'(4 * n) : base;
    for (int b = 0; b < 10; b++) begin
      if (list[b]) begin
        k++;
        x.r = bit2reg(b);
        x.a = a;
        x.last = (k == n);
        exp_q.push_back(x);
        a = a + 32'd4;
      end
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the edge following done.
  task automatic run(input vec_t v);
    int  cyc;
    int  stalls;
    bit  seen_done;
    xfer_t x;
    exp_q.delete();
    push_model(v.list, v.base, v.decr);
    start = 1'b1; list_in = v.list; base_addr = v.base; decr = v.decr;
    @(posedge clk); #1;
    start = 1'b0; list_in = 10'($urandom);
    cyc = 1; stalls = v.stall; seen_done = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    while (cyc < 60 && !seen_done) begin
      start = 1'b0;
      if (req_valid && stalls > 0) begin
        req_ready = 1'b0;
        stalls--;
        if (v.mid_start) begin
          start = 1'b1; list_in = 10'h3FF; base_addr = 32'h0; decr = 1'b1;
        end
      end else begin
        req_ready = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 32'(cyc), 32'(v.n + 1 + v.stall));
        check("wb_addr", wb_addr, v.wb);
        check("all_xfers_seen", 32'(exp_q.size()), 32'd0);
        check("fault_low", 32'(fault), 32'd0);
      end else if (req_valid) begin
        if (exp_q.size() == 0) begin
          check("unexp_req", 32'(req_valid), 32'd0);
        end else begin
          x = exp_q[0];
          check("req_reg", 32'(req_reg), 32'(x.r));
          check("req_addr", req_addr, x.a);
          check("req_last", 32'(req_last), 32'(x.last));
          if (req_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 32'(done), 32'd1);
    check("busy_fall", 32'(busy), 32'd0);
    $display("seq list=%03h base=%08h decr=%0d stall=%0d -> done_cycle=%0d wb=%08h",
             v.list, v.base, v.decr, v.stall, cyc - 1, wb_addr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    check({tag, "_req_last"}, 32'(req_last), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_req_reg"}, 32'(req_reg), 32'd0);
    check({tag, "_req_addr"}, req_addr, 32'd0);
    check({tag, "_wb_addr"}, wb_addr, 32'd0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    rst_n = 1'b0; start = 1'b0; list_in = '0; base_addr = '0; decr = 1'b0; req_ready = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;

    //         list      base           decr n   wb             stall mid
    vecs.push_back('{10'h005, 32'h2000_0000, 1'b0, 2,  32'h2000_0008, 0, 1'b0});
    vecs.push_back('{10'h110, 32'h2000_0100, 1'b1, 2,  32'h2000_00F8, 0, 1'b0});
    vecs.push_back('{10'h000, 32'h1234_5670, 1'b0, 0,  32'h1234_5670, 0, 1'b0});
    vecs.push_back('{10'h201, 32'h4000_0000, 1'b0, 2,  32'h4000_0008, 3, 1'b1});
    vecs.push_back('{10'h3FF, 32'hFFFF_FFF8, 1'b0, 10, 32'h0000_0020, 0, 1'b0});
    vecs.push_back('{10'h3FF, 32'h0000_0100, 1'b1, 10, 32'h0000_00D8, 0, 1'b0});
    vecs.push_back('{10'h000, 32'h8000_0000, 1'b1, 0,  32'h8000_0000, 0, 1'b0});
    vecs.push_back('{10'h080, 32'h0000_0000, 1'b1, 1,  32'hFFFF_FFFC, 1, 1'b1});
`ifndef REG_LIST_ALIGN_CHECK_EN
    // Without the check, base bits [1:0] simply ride along
    vecs.push_back('{10'h003, 32'h2000_0002, 1'b0, 2,  32'h2000_000A, 0, 1'b0});
`endif
    foreach (vecs[i]) run(vecs[i]);

    // Reset during the 2nd handshake of a 5-register list
    exp_q.delete();
    start = 1'b1; list_in = 10'h01F; base_addr = 32'h0000_1000; decr = 1'b0; req_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req_addr", req_addr, 32'h0000_1004);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-transfer applied");
    run(vecs[0]);

`ifdef REG_LIST_ALIGN_CHECK_EN
    start = 1'b1; list_in = 10'h0FF; base_addr = 32'h2000_0002; decr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("align_done", 32'(done), 32'd1);
    check("align_fault", 32'(fault), 32'd1);
    check("align_no_req", 32'(req_valid), 32'd0);
    check("align_wb", wb_addr, 32'h2000_0002);
    @(posedge clk); #1;
    check("align_fault_pulse", 32'(fault), 32'd0);
    check("align_idle", 32'(busy), 32'd0);
    $display("align fault base=20000002 checked");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_list_seq.md
# reg_list_seq

Register-list transfer sequencer for the Cortex-M0 load/store-multiple path (LDM, STM, PUSH, POP). Consumes the same 10-bit register list whose size is already reduced to a byte offset by the list-size logic. Walks the list lowest register first, issuing one word transfer per handshake with the matching register index and word address. On completion, reports the base write-back value.

## Interface
- `WIDTH_ADDR`, default 32: address and base width.
- `LIST_W`, default 10: register-list width.
  - bits 0–7 map to R0–R7.
  - bit 8 maps to R14 (LR).
  - bit 9 maps to R15 (PC).

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new list transfer. Sampled only in IDLE.
- `list_in`  in  LIST_W: register list, captured on an accepted start.
- `base_addr`  in  WIDTH_ADDR: base register value, captured on an accepted start.
- `decr`  in  1: 1 selects decrement-before (PUSH). 0 selects increment-after (LDM/STM/POP).
- `busy`  out  1: high from the cycle after an accepted start until done is asserted, inclusive.
- `req_valid`  out  1: transfer request valid.
- `req_ready`  in  1: memory side accepts the request.
- `req_reg`  out  4: register index, 0–7, 14 or 15.
- `req_addr`  out  WIDTH_ADDR: word address of the transfer.
- `req_last`  out  1: current request is the final one.
- `done`  out  1: one-cycle pulse at the end of the sequence.
- `wb_addr`  out  WIDTH_ADDR: base write-back value. Valid while done is high and held until the next accepted start.
- `fault`  out  1: one-cycle pulse on an alignment fault. Present only with the macro; tied 0 otherwise.

## Operation
- States: IDLE, XFER, DONE.
- **IDLE**
  - start=1 captures list, base and decr.
  - Next state is XFER, or DONE if the list is zero.
  - n = popcount(list), range 0–10.
  - The first address is base when decr=0, and base − 4·n when decr=1.
- **XFER**
  - req_valid=1.
  - req_reg is the index of the lowest set bit of the remaining list: bit 8 maps to 14, bit 9 maps to 15.
  - req_addr is the current address.
  - req_last=1 when exactly one bit remains.
- **Handshake**
  - A handshake is req_valid & req_ready.
  - It clears the lowest remaining bit and adds 4 to the address, modulo 2^WIDTH_ADDR (wrap allowed, no flag).
  - The handshake on the last bit moves the FSM to DONE.
  - Without a handshake, req_reg, req_addr and req_last hold stable. req_valid never drops before its handshake.
- **DONE**
  - done=1 for one cycle, then IDLE.
  - wb_addr is base + 4·n when decr=0, and base − 4·n when decr=1.
- All arithmetic is WIDTH_ADDR-bit unsigned with wrap. 4·n is at most 40.
- **Empty list:** no request is issued. DONE follows in the next cycle with wb_addr = base.
- **start while busy:** ignored. Captured state is unchanged.
- **Reset**, including mid-transfer: the FSM returns to IDLE and the sequence is abandoned.
  - busy, req_valid, req_last, done and fault all return to 0.
  - req_reg=0, req_addr=0, wb_addr=0.

## Timing
- The start cycle is T.
- req_valid rises at T+1. busy rises at T+1.
- With req_ready held high, one transfer completes per cycle. The k-th transfer (k=1..n) handshakes at T+k.
- done is asserted at T+n+1. busy falls at T+n+2. A new start is accepted in the cycle done is asserted +1, i.e. IDLE.
- Empty list: done is asserted at T+1.
- Outputs are registered. No combinational path from req_ready to req_valid, req_reg or req_addr.

## Configuration
- `REG_LIST_ALIGN_CHECK_EN`
  - **Defined:** an accepted start with base_addr[1:0] ≠ 0 goes IDLE→DONE and issues no requests. fault and done both pulse at T+1, and wb_addr = base unchanged.
  - **Undefined:** base bits [1:0] are ignored and transfers proceed. The fault port exists but is constant 0.

## Structure
- Shared package `m0_pkg` holds:
  - the state enum;
  - `WORD_BYTES=4`;
  - `REG_LR=4'd14` and `REG_PC=4'd15`;
  - list-bit-to-register mapping constants.
- One sub-module, `lowest_set_idx`: combinational priority encoder from a LIST_W list to the 4-bit register index plus a one-hot clear mask.
- The popcount is computed inline. It is needed only in IDLE.

## Test plan
- list=10'b0000000101, base=0x2000_0000, decr=0, ready=1 → reg 0 @0x2000_0000 at T+1, reg 2 @0x2000_0004 with last at T+2, done at T+3, wb=0x2000_0008.
- PUSH list=10'b0100010000 (R4, LR), base=0x2000_0100, decr=1 → reg 4 @0x2000_00F8, then reg 14 @0x2000_00FC with last, wb=0x2000_00F8.
- list=0 → no req_valid, done at T+1, wb=base.
- list=10'b1000000001, with ready low for 3 cycles on the first request → reg 0 and address held stable for 4 cycles. Then reg 15, then done. A start pulsed mid-transfer has no effect.
- list=10'h3FF, base=0xFFFF_FFF8, decr=0 → 10 transfers with address wrapping to 0x0000_0000 at the 3rd transfer, wb=0x0000_0020.
- rst_n low at 2nd handshake of a 5-register list → all outputs 0 immediately. A subsequent start runs cleanly. With `REG_LIST_ALIGN_CHECK_EN`, base=0x...2 → fault and done at T+1, no requests.
